// File: rtl/display_pkg.sv
// display_pkg: shared constants and types for the six-digit clock display.
//   - Active-low 7-segment codes {g,f,e,d,c,b,a} for 0-9, dash and blank.
//   - Internal digit codes: 0-9 are decimal values, CODE_DASH and CODE_BLANK
//     are the two non-numeric glyphs.
//   - Digit positions (0 = seconds ones ... 5 = hours tens).
//   - FSM state encoding and the order in which fields are converted.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam int NUM_DIGITS   = 6;
    localparam int DIG_SEC_ONES = 0;
    localparam int DIG_SEC_TENS = 1;
    localparam int DIG_MIN_ONES = 2;
    localparam int DIG_MIN_TENS = 3;
    localparam int DIG_HR_ONES  = 4;
    localparam int DIG_HR_TENS  = 5;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        CONV    = 2'd1,
        LOAD    = 2'd2,
        WAIT    = 2'd3
    } disp_state_t;

    typedef enum logic [1:0] {
        FIELD_SEC = 2'd0,
        FIELD_MIN = 2'd1,
        FIELD_HR  = 2'd2
    } conv_field_t;

    // Map an internal digit code to its active-low segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:      s = SEG_0;
            4'd1:      s = SEG_1;
            4'd2:      s = SEG_2;
            4'd3:      s = SEG_3;
            4'd4:      s = SEG_4;
            4'd5:      s = SEG_5;
            4'd6:      s = SEG_6;
            4'd7:      s = SEG_7;
            4'd8:      s = SEG_8;
            4'd9:      s = SEG_9;
            CODE_DASH: s = SEG_DASH;
            default:   s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 6-bit binary to two-digit BCD converter.
//   clk   : clock
//   srst  : synchronous active-high reset
//   start : load value and begin converting (accepted in any cycle)
//   value : binary input 0-63
//   done  : one-cycle pulse; tens/ones are valid from this cycle until
//           the next start
//   tens  : tens digit 0-6
//   ones  : ones digit 0-9
// Repeated subtraction of 10: one cycle per ten, plus one finishing cycle.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic [5:0] value,
    output logic       done,
    output logic [2:0] tens,
    output logic [3:0] ones
);

    logic       busy_reg;
    logic       done_reg;
    logic [5:0] work_reg;
    logic [2:0] tens_reg;
    logic [3:0] ones_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            work_reg <= '0;
            tens_reg <= '0;
            ones_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                busy_reg <= 1'b1;
                work_reg <= value;
                tens_reg <= '0;
            end else if (busy_reg) begin
                if (work_reg >= 6'd10) begin
                    work_reg <= work_reg - 6'd10;
                    tens_reg <= tens_reg + 3'd1;
                end else begin
                    // Remainder is below 10, so the low nibble is the ones digit.
                    ones_reg <= work_reg[3:0];
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign done = done_reg;
    assign tens = tens_reg;
    assign ones = ones_reg;

endmodule

// File: rtl/clock_display.sv
// clock_display: drives a six-digit multiplexed common-anode 7-segment
// display with HH MM SS from the time-keeping counters.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   hours     : binary hours, valid 1-12
//   minutes   : binary minutes, valid 0-59
//   seconds   : binary seconds, valid 0-59
//   am_pm     : 1 = PM (lit as the decimal point of digit 0)
//   setting_h : hours being set, hours digits blink
//   setting_m : minutes being set, minutes digits blink
//   seg       : segments {g,f,e,d,c,b,a}, active-low
//   an        : digit enables, active-low; an[0] seconds ones, an[5] hours tens
//   dp        : decimal point, active-low
// Inputs are snapshotted once per frame (at the 5->0 scan wrap), converted
// to BCD sequentially and loaded into display registers as one unit, so a
// frame never mixes old and new time values.
module clock_display
    import display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       am_pm,
    input  logic       setting_h,
    input  logic       setting_m,
    output logic [6:0] seg,
    output logic [5:0] an,
    output logic       dp
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Scan and blink timing
    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [2:0]         digit_idx_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;
    logic               scan_tc;
    logic               frame_wrap;

    // FSM and converter handshake
    disp_state_t state_reg, state_next;
    conv_field_t field_reg, field_next;
    logic        conv_busy_reg, conv_busy_next;
    logic        capture_en;
    logic        load_en;
    logic        conv_start;
    logic        conv_done;
    logic [5:0]  conv_value;
    logic [2:0]  conv_tens;
    logic [3:0]  conv_ones;

    // Snapshot and BCD registers
    logic [3:0] snap_hours_reg;
    logic [5:0] snap_minutes_reg;
    logic [5:0] snap_seconds_reg;
    logic       snap_am_pm_reg;
    logic       snap_set_h_reg;
    logic       snap_set_m_reg;
    logic [2:0] sec_tens_reg, min_tens_reg, hr_tens_reg;
    logic [3:0] sec_ones_reg, min_ones_reg, hr_ones_reg;

    // Display registers
    logic [3:0] disp_code_reg [NUM_DIGITS];
    logic [3:0] load_code     [NUM_DIGITS];
    logic       disp_set_h_reg;
    logic       disp_set_m_reg;
    logic       disp_am_pm_reg;
    logic       disp_valid_reg;
    logic [6:0] digit_seg     [NUM_DIGITS];
    logic [6:0] cur_seg;

    logic [6:0] seg_reg;
    logic [5:0] an_reg;
    logic       dp_reg;

    assign scan_tc    = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));
    assign frame_wrap = scan_tc && (digit_idx_reg == 3'(DIG_HR_TENS));

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_reg    <= '0;
            digit_idx_reg   <= '0;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else begin
            if (scan_tc) begin
                scan_cnt_reg  <= '0;
                digit_idx_reg <= (digit_idx_reg == 3'(DIG_HR_TENS)) ? 3'd0 : digit_idx_reg + 3'd1;
            end else begin
                scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
            end
            if (blink_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CAPTURE;
            field_reg     <= FIELD_SEC;
            conv_busy_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            field_reg     <= field_next;
            conv_busy_reg <= conv_busy_next;
        end
    end

    // Fields are converted seconds -> minutes -> hours. The next conversion
    // is started in the same cycle the previous one reports done, which keeps
    // the worst case (63, 63, 15) at 21 cycles from CAPTURE to LOAD.
    always_comb begin
        state_next     = state_reg;
        field_next     = field_reg;
        conv_busy_next = conv_busy_reg;
        capture_en     = 1'b0;
        load_en        = 1'b0;
        conv_start     = 1'b0;
        case (state_reg)
            CAPTURE: begin
                capture_en     = 1'b1;
                field_next     = FIELD_SEC;
                conv_busy_next = 1'b0;
                state_next     = CONV;
            end
            CONV: begin
                if (!conv_busy_reg) begin
                    conv_start     = 1'b1;
                    conv_busy_next = 1'b1;
                end else if (conv_done) begin
                    case (field_reg)
                        FIELD_SEC: begin
                            field_next = FIELD_MIN;
                            conv_start = 1'b1;
                        end
                        FIELD_MIN: begin
                            field_next = FIELD_HR;
                            conv_start = 1'b1;
                        end
                        default: begin
                            conv_busy_next = 1'b0;
                            state_next     = LOAD;
                        end
                    endcase
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                state_next = frame_wrap ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (frame_wrap) begin
                    state_next = CAPTURE;
                end
            end
            default: state_next = CAPTURE;
        endcase
    end

    always_comb begin
        case (field_next)
            FIELD_SEC: conv_value = snap_seconds_reg;
            FIELD_MIN: conv_value = snap_minutes_reg;
            default:   conv_value = {2'b00, snap_hours_reg};
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .srst  (rst),
        .start (conv_start),
        .value (conv_value),
        .done  (conv_done),
        .tens  (conv_tens),
        .ones  (conv_ones)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_hours_reg   <= '0;
            snap_minutes_reg <= '0;
            snap_seconds_reg <= '0;
            snap_am_pm_reg   <= 1'b0;
            snap_set_h_reg   <= 1'b0;
            snap_set_m_reg   <= 1'b0;
            sec_tens_reg     <= '0;
            sec_ones_reg     <= '0;
            min_tens_reg     <= '0;
            min_ones_reg     <= '0;
            hr_tens_reg      <= '0;
            hr_ones_reg      <= '0;
        end else begin
            if (capture_en) begin
                snap_hours_reg   <= hours;
                snap_minutes_reg <= minutes;
                snap_seconds_reg <= seconds;
                snap_am_pm_reg   <= am_pm;
                snap_set_h_reg   <= setting_h;
                snap_set_m_reg   <= setting_m;
            end
            if ((state_reg == CONV) && conv_busy_reg && conv_done) begin
                case (field_reg)
                    FIELD_SEC: begin
                        sec_tens_reg <= conv_tens;
                        sec_ones_reg <= conv_ones;
                    end
                    FIELD_MIN: begin
                        min_tens_reg <= conv_tens;
                        min_ones_reg <= conv_ones;
                    end
                    default: begin
                        hr_tens_reg <= conv_tens;
                        hr_ones_reg <= conv_ones;
                    end
                endcase
            end
        end
    end

    // Digit codes written at LOAD: out-of-range fields become dashes and a
    // zero hours tens digit is blanked.
    always_comb begin
        logic sec_ok, min_ok, hr_ok;
        sec_ok = (snap_seconds_reg <= 6'd59);
        min_ok = (snap_minutes_reg <= 6'd59);
        hr_ok  = (snap_hours_reg != 4'd0) && (snap_hours_reg <= 4'd12);
        load_code[DIG_SEC_ONES] = sec_ok ? sec_ones_reg : CODE_DASH;
        load_code[DIG_SEC_TENS] = sec_ok ? {1'b0, sec_tens_reg} : CODE_DASH;
        load_code[DIG_MIN_ONES] = min_ok ? min_ones_reg : CODE_DASH;
        load_code[DIG_MIN_TENS] = min_ok ? {1'b0, min_tens_reg} : CODE_DASH;
        load_code[DIG_HR_ONES]  = hr_ok  ? hr_ones_reg : CODE_DASH;
        if (!hr_ok) begin
            load_code[DIG_HR_TENS] = CODE_DASH;
        end else if (hr_tens_reg == 3'd0) begin
            load_code[DIG_HR_TENS] = CODE_BLANK;
        end else begin
            load_code[DIG_HR_TENS] = {1'b0, hr_tens_reg};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_code_reg[i] <= '0;
            end
            disp_set_h_reg <= 1'b0;
            disp_set_m_reg <= 1'b0;
            disp_am_pm_reg <= 1'b0;
            disp_valid_reg <= 1'b0;
        end else if (load_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                disp_code_reg[i] <= load_code[i];
            end
            disp_set_h_reg <= snap_set_h_reg;
            disp_set_m_reg <= snap_set_m_reg;
            disp_am_pm_reg <= snap_am_pm_reg;
            disp_valid_reg <= 1'b1;
        end
    end

    // Per-digit segment pattern with blink blanking; anodes keep scanning
    // while a field is blanked.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic blink_blank;
            if (gi >= DIG_HR_ONES) begin : g_hr
                assign blink_blank = blink_phase_reg & disp_set_h_reg;
            end else if (gi >= DIG_MIN_ONES) begin : g_min
                assign blink_blank = blink_phase_reg & disp_set_m_reg;
            end else begin : g_sec
                assign blink_blank = 1'b0;
            end
            assign digit_seg[gi] = blink_blank ? SEG_BLANK : seg_decode(disp_code_reg[gi]);
        end
    endgenerate

    always_comb begin
        cur_seg = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx_reg == 3'(i)) begin
                cur_seg = digit_seg[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !disp_valid_reg) begin
            an_reg  <= 6'b111111;
            seg_reg <= SEG_BLANK;
            dp_reg  <= 1'b1;
        end else begin
            an_reg  <= ~(6'b000001 << digit_idx_reg);
            seg_reg <= cur_seg;
            dp_reg  <= ~((digit_idx_reg == 3'(DIG_SEC_ONES)) & disp_am_pm_reg);
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_clock_display.sv
module tb_clock_display;
    import display_pkg::*;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;
    localparam int BUDGET    = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
    logic       setting_h;
    logic       setting_m;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    typedef struct {
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       blink;
        int         digit;
    } exp_t;

    exp_t sb[$];

    clock_display #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .am_pm     (am_pm),
        .setting_h (setting_h),
        .setting_m (setting_m),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    // Cycles since the last reset; matches the free-running scan/blink count.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic drive(input int h, input int m, input int s,
                         input bit pm, input bit seth, input bit setm);
        hours     = 4'(h);
        minutes   = 6'(m);
        seconds   = 6'(s);
        am_pm     = pm;
        setting_h = seth;
        setting_m = setm;
    endtask

    // Push the six expected digits of a frame showing h:m:s.
    task automatic push_frame(input int h, input int m, input int s,
                              input bit pm, input bit seth, input bit setm);
        logic [6:0] dash;
        logic [6:0] segs [6];
        logic [5:0] one_hot;
        exp_t       e;
        dash    = 7'b0111111;
        one_hot = 6'b000001;
        segs[0] = (s <= 59) ? ref_seg(s % 10) : dash;
        segs[1] = (s <= 59) ? ref_seg(s / 10) : dash;
        segs[2] = (m <= 59) ? ref_seg(m % 10) : dash;
        segs[3] = (m <= 59) ? ref_seg(m / 10) : dash;
        if (h >= 1 && h <= 12) begin
            segs[4] = ref_seg(h % 10);
            segs[5] = (h / 10 == 0) ? 7'b1111111 : ref_seg(h / 10);
        end else begin
            segs[4] = dash;
            segs[5] = dash;
        end
        for (int d = 0; d < 6; d++) begin
            e.an    = ~(one_hot << d);
            e.seg   = segs[d];
            e.dp    = (d == 0) ? ~pm : 1'b1;
            e.blink = (d >= 4) ? seth : ((d >= 2) ? setm : 1'b0);
            e.digit = d;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for a fresh appearance of an == target at a negedge.
    task automatic wait_an(input logic [5:0] target, output bit ok);
        int n;
        n = 0;
        while (an === target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        while (an !== target && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        ok = (an === target) && (n < BUDGET);
    endtask

    // Let two frame captures pass so the display holds the current inputs.
    task automatic settle();
        bit ok;
        repeat (2) begin
            wait_an(6'b111110, ok);
            asserts++;
            if (!ok) begin
                fails++;
                $display("FAIL settle_timeout: an=%b required 111110 within %0d cycles", an, BUDGET);
            end
        end
    endtask

    // Pop six expected digits and compare against the next displayed frame.
    task automatic collect_frame(input string tag);
        bit         ok;
        exp_t       e;
        logic [6:0] want_seg;
        int         phase;
        wait_an(6'b111110, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL %s frame_start: an=%b required 111110 within %0d cycles", tag, an, BUDGET);
            sb.delete();
            return;
        end
        for (int d = 0; d < 6; d++) begin
            if (d > 0) repeat (SCAN_DIV) @(negedge clk);
            asserts++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL %s scoreboard_empty: digit %0d has no expected entry", tag, d);
                return;
            end
            e = sb.pop_front();
            // Output shown now was registered in the previous cycle.
            phase    = ((cyc - 1) / BLINK_DIV) % 2;
            want_seg = (e.blink && phase == 1) ? 7'b1111111 : e.seg;
            $display("%s digit %0d: an=%b seg=%b dp=%b (exp an=%b seg=%b dp=%b)",
                     tag, e.digit, an, seg, dp, e.an, want_seg, e.dp);
            asserts++;
            if (an !== e.an) begin
                fails++;
                $display("FAIL %s an d%0d: got %b required %b", tag, e.digit, an, e.an);
            end
            asserts++;
            if (seg !== want_seg) begin
                fails++;
                $display("FAIL %s seg d%0d: got %b required %b", tag, e.digit, seg, want_seg);
            end
            asserts++;
            if (dp !== e.dp) begin
                fails++;
                $display("FAIL %s dp d%0d: got %b required %b", tag, e.digit, dp, e.dp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(12, 34, 56, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset: an=%b seg=%b dp=%b", an, seg, dp);
        asserts++;
        if (an !== 6'b111111) begin
            fails++;
            $display("FAIL reset_an: got %b required 111111", an);
        end
        asserts++;
        if (seg !== 7'b1111111) begin
            fails++;
            $display("FAIL reset_seg: got %b required 1111111", seg);
        end
        asserts++;
        if (dp !== 1'b1) begin
            fails++;
            $display("FAIL reset_dp: got %b required 1", dp);
        end
        rst = 1'b0;
        // First LOAD is about 19 cycles after reset; outputs stay dark until then.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            asserts++;
            if ({an, seg, dp} !== 14'h3fff) begin
                fails++;
                $display("FAIL reset_hold c%0d: got an=%b seg=%b dp=%b required all ones", cyc, an, seg, dp);
            end
        end
    endtask

    task automatic test_normal();
        settle();
        push_frame(12, 34, 56, 1'b1, 1'b0, 1'b0);
        collect_frame("normal_pm");
        drive(10, 7, 3, 1'b0, 1'b0, 1'b0);
        settle();
        push_frame(10, 7, 3, 1'b0, 1'b0, 1'b0);
        collect_frame("normal_am");
    endtask

    task automatic test_leading_midframe();
        bit ok;
        drive(9, 7, 59, 1'b0, 1'b0, 1'b0);
        settle();
        push_frame(9, 7, 59, 1'b0, 1'b0, 1'b0);
        collect_frame("leading_blank");
        wait_an(6'b111011, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL midframe_digit2: an=%b required 111011 within %0d cycles", an, BUDGET);
        end
        seconds = 6'd0;
        push_frame(9, 7, 59, 1'b0, 1'b0, 1'b0);
        collect_frame("midframe_old");
        push_frame(9, 7, 0, 1'b0, 1'b0, 1'b0);
        collect_frame("midframe_new");
    endtask

    task automatic test_blink();
        drive(3, 45, 12, 1'b0, 1'b0, 1'b1);
        settle();
        for (int f = 0; f < 4; f++) begin
            push_frame(3, 45, 12, 1'b0, 1'b0, 1'b1);
            collect_frame("blink_min");
        end
        drive(11, 28, 40, 1'b1, 1'b1, 1'b0);
        settle();
        for (int f = 0; f < 3; f++) begin
            push_frame(11, 28, 40, 1'b1, 1'b1, 1'b0);
            collect_frame("blink_hr");
        end
    endtask

    task automatic test_range();
        drive(12, 60, 5, 1'b0, 1'b0, 1'b0);
        settle();
        push_frame(12, 60, 5, 1'b0, 1'b0, 1'b0);
        collect_frame("range_min60");
        drive(0, 59, 63, 1'b1, 1'b0, 1'b0);
        settle();
        push_frame(0, 59, 63, 1'b1, 1'b0, 1'b0);
        collect_frame("range_hr0_sec63");
        drive(13, 0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        push_frame(13, 0, 0, 1'b0, 1'b0, 1'b0);
        collect_frame("range_hr13");
    endtask

    task automatic test_reset_conv();
        bit ok;
        drive(12, 34, 56, 1'b1, 1'b0, 1'b0);
        settle();
        // Digit 0 just became visible: the FSM left CAPTURE and is converting.
        wait_an(6'b111110, ok);
        asserts++;
        if (!ok) begin
            fails++;
            $display("FAIL rst_conv_sync: an=%b required 111110 within %0d cycles", an, BUDGET);
        end
        rst = 1'b1;
        @(negedge clk);
        $display("reset_conv: an=%b seg=%b dp=%b", an, seg, dp);
        asserts++;
        if ({an, seg, dp} !== 14'h3fff) begin
            fails++;
            $display("FAIL rst_conv_out: got an=%b seg=%b dp=%b required all ones", an, seg, dp);
        end
        asserts++;
        if (dut.state_reg !== CAPTURE) begin
            fails++;
            $display("FAIL rst_conv_state: got %0d required %0d", dut.state_reg, CAPTURE);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            asserts++;
            if ({an, seg, dp} !== 14'h3fff) begin
                fails++;
                $display("FAIL rst_conv_hold c%0d: got an=%b seg=%b dp=%b required all ones", cyc, an, seg, dp);
            end
        end
        settle();
        push_frame(12, 34, 56, 1'b1, 1'b0, 1'b0);
        collect_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_leading_midframe();
        test_blink();
        test_range();
        test_reset_conv();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
